// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: forward-select encodings, register-address
// width and the per-stage destination-register record.
package cpu_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from WB-stage data
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from MEM-stage ALU result

    // Destination info carried down the shadow pipeline.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_info_t;

    localparam stage_info_t STAGE_INVALID = '{rd: '0, regwrite: 1'b0, memread: 1'b0};

endpackage

// File: rtl/fwd_select.sv
// Forward-select decision for one EX operand: the youngest older writer of the
// source register wins, so the ex_ entry (MEM next cycle) beats the mem_ entry
// (WB next cycle). Register 0 is never forwarded.
module fwd_select
    import cpu_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              use_src,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    output logic [1:0]        sel
);

    // Priority compare: ex_ producer first, then mem_ producer, else register file.
    always_comb begin
        sel = FWD_REG;
        if (use_src && ex_regwrite && (ex_rd != '0) && (ex_rd == src)) begin
            sel = FWD_MEM;
        end else if (use_src && mem_regwrite && (mem_rd != '0) && (mem_rd == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller beside the ID/EX register. Tracks the
// destination info of instructions in EX/MEM/WB, registers the EX operand
// forward selects, and drives load-use stall, branch flush and freeze
// controls plus a saturating load-use stall counter.
module hazard_fwd_ctrl #(
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_branch_taken,
    input  logic              mem_wait,
    output logic [1:0]        forwarda,
    output logic [1:0]        forwardb,
    output logic              pc_write,
    output logic              flush_if_id,
    output logic              bubble_id_ex,
    output logic [CNT_W-1:0]  stall_count
);

    import cpu_pkg::*;

    stage_info_t      ex_q, ex_d;
    stage_info_t      mem_q, mem_d;
    stage_info_t      wb_q, wb_d;
    logic [1:0]       fwda_q, fwda_d;
    logic [1:0]       fwdb_q, fwdb_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic             load_use;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;

    // The WB entry and the younger stages' load flags complete the shadow
    // pipeline but no decision here consumes them.
    logic             unused_shadow;
    assign unused_shadow = ^{wb_q, mem_q.memread};

    fwd_select u_fwd_a (
        .src          (id_rs),
        .use_src      (id_uses_rs),
        .ex_rd        (ex_q.rd),
        .ex_regwrite  (ex_q.regwrite),
        .mem_rd       (mem_q.rd),
        .mem_regwrite (mem_q.regwrite),
        .sel          (sel_a)
    );

    fwd_select u_fwd_b (
        .src          (id_rt),
        .use_src      (id_uses_rt),
        .ex_rd        (ex_q.rd),
        .ex_regwrite  (ex_q.regwrite),
        .mem_rd       (mem_q.rd),
        .mem_regwrite (mem_q.regwrite),
        .sel          (sel_b)
    );

    // Load in EX whose result the ID instruction needs: one bubble is enough,
    // since the load reaches MEM next cycle and WB forwarding takes over.
    always_comb begin
        load_use = ex_q.memread && ex_q.regwrite && (ex_q.rd != '0) &&
                   ((id_uses_rs && (ex_q.rd == id_rs)) ||
                    (id_uses_rt && (ex_q.rd == id_rt)));
    end

    // Pipeline controls, by priority: reset, freeze, taken branch, load-use.
    always_comb begin
        // NOTE: every output gets a default before the branches so no path
        // leaves it unassigned, which would infer a latch.
        pc_write     = 1'b1;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        if (reset) begin
            pc_write = 1'b1;
        end else if (mem_wait) begin
            pc_write = 1'b0;
        end else if (ex_branch_taken) begin
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            bubble_id_ex = 1'b1;
        end
    end

    // Next state: hold everything while frozen, otherwise advance the shadow
    // pipeline, latch the forward selects and count non-branch load-use stalls.
    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        fwda_d  = fwda_q;
        fwdb_d  = fwdb_q;
        stall_d = stall_q;
        if (!mem_wait) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (bubble_id_ex) begin
                ex_d   = STAGE_INVALID;
                fwda_d = FWD_REG;
                fwdb_d = FWD_REG;
            end else begin
                ex_d   = '{rd: id_rd, regwrite: id_regwrite, memread: id_memread};
                fwda_d = sel_a;
                fwdb_d = sel_b;
            end
            if (load_use && !ex_branch_taken && (stall_q != '1)) begin
                stall_d = stall_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset; a pending stall or freeze is
    // discarded by reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            ex_q    <= STAGE_INVALID;
            mem_q   <= STAGE_INVALID;
            wb_q    <= STAGE_INVALID;
            fwda_q  <= FWD_REG;
            fwdb_q  <= FWD_REG;
            stall_q <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwda_q  <= fwda_d;
            fwdb_q  <= fwdb_d;
            stall_q <= stall_d;
        end
    end

    assign forwarda    = fwda_q;
    assign forwardb    = fwdb_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// history-based reference model.
module tb_hazard_fwd_ctrl;

    localparam int AW    = 5;
    localparam int CW    = 6;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          id_uses_rs, id_uses_rt, id_regwrite, id_memread;
    logic          ex_branch_taken, mem_wait;
    logic [1:0]    forwarda, forwardb;
    logic          pc_write, flush_if_id, bubble_id_ex;
    logic [CW-1:0] stall_count;

    int n_checks = 0;
    int n_errors = 0;

    hazard_fwd_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_regwrite     (id_regwrite),
        .id_memread      (id_memread),
        .ex_branch_taken (ex_branch_taken),
        .mem_wait        (mem_wait),
        .forwarda        (forwarda),
        .forwardb        (forwardb),
        .pc_write        (pc_write),
        .flush_if_id     (flush_if_id),
        .bubble_id_ex    (bubble_id_ex),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // History of what entered EX, newest last; a bubble is an entry with no write.
    typedef struct { int rd; bit rw; bit mr; } ent_t;
    ent_t hist[$];
    int   exp_fa, exp_fb, exp_cnt;
    bit   model_valid = 1'b0;

    function automatic bit needs(int r);
        return (id_uses_rs && int'(id_rs) == r) || (id_uses_rt && int'(id_rt) == r);
    endfunction

    function automatic bit m_load_use();
        ent_t e = hist[hist.size()-1];
        return e.mr && e.rw && e.rd != 0 && needs(e.rd);
    endfunction

    function automatic bit m_bubble();
        return !reset && !mem_wait && (ex_branch_taken || m_load_use());
    endfunction

    function automatic int m_sel(int src, bit uses);
        ent_t newer = hist[hist.size()-1];
        ent_t older = hist[hist.size()-2];
        if (!uses || src == 0) return 0;
        if (newer.rw && newer.rd == src) return 2;
        if (older.rw && older.rd == src) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        ent_t inv;
        ent_t nw;
        inv = '{rd: 0, rw: 1'b0, mr: 1'b0};
        if (reset) begin
            hist = {inv, inv};
            exp_fa = 0; exp_fb = 0; exp_cnt = 0;
            model_valid = 1'b1;
        end else if (model_valid && !mem_wait) begin
            bit bub;
            bub = m_bubble();
            exp_fa = bub ? 0 : m_sel(int'(id_rs), id_uses_rs);
            exp_fb = bub ? 0 : m_sel(int'(id_rt), id_uses_rt);
            if (m_load_use() && !ex_branch_taken && exp_cnt < CMAX) exp_cnt++;
            nw = bub ? inv : '{rd: int'(id_rd), rw: id_regwrite, mr: id_memread};
            hist.push_back(nw);
            if (hist.size() > 4) void'(hist.pop_front());
        end
    end

    // Compare process: every cycle once the model has seen a reset edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("pc_write",     32'(pc_write),     32'(reset ? 1'b1 : (!mem_wait && (ex_branch_taken || !m_load_use()))));
            check("flush_if_id",  32'(flush_if_id),  32'(!reset && !mem_wait && ex_branch_taken));
            check("bubble_id_ex", 32'(bubble_id_ex), 32'(m_bubble()));
            check("forwarda",     32'(forwarda),     32'(exp_fa));
            check("forwardb",     32'(forwardb),     32'(exp_fb));
            check("stall_count",  32'(stall_count),  32'(exp_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int rs, input int rt, input int rd, input bit urs, input bit urt,
                        input bit rw, input bit mr, input bit br, input bit mw, input bit rst);
        @(posedge clk);
        #1;
        id_rs = AW'(rs); id_rt = AW'(rt); id_rd = AW'(rd);
        id_uses_rs = urs; id_uses_rt = urt; id_regwrite = rw; id_memread = mr;
        ex_branch_taken = br; mem_wait = mw; reset = rst;
        @(negedge clk);
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ALU op rd <- rs, rt
    task automatic alu(input int rd, input int rs, input int rt);
        step(rs, rt, rd, 1, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic lw(input int rd);
        step(1, 0, rd, 1, 0, 1, 1, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        id_rs = '0; id_rt = '0; id_rd = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_regwrite = 0; id_memread = 0;
        ex_branch_taken = 0; mem_wait = 0;

        // Reset: combinational controls read 1/0/0.
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        check("rst_pc_write", 32'(pc_write), 32'd1);
        check("rst_flush",    32'(flush_if_id), 32'd0);
        check("rst_bubble",   32'(bubble_id_ex), 32'd0);

        // add r3 <- r1,r2 with no prior writers.
        alu(3, 1, 2);
        check("init_fa", 32'(forwarda), 32'd0);
        check("init_pc", 32'(pc_write), 32'd1);
        check("init_cnt", 32'(stall_count), 32'd0);
        nop();
        check("indep_fa", 32'(forwarda), 32'd0);
        check("indep_fb", 32'(forwardb), 32'd0);

        // Back-to-back dependency -> MEM forward.
        alu(5, 1, 2); alu(6, 5, 5); nop();
        check("b2b_fa", 32'(forwarda), 32'd2);
        check("b2b_fb", 32'(forwardb), 32'd2);

        // One independent instruction between -> WB forward.
        alu(5, 1, 2); alu(9, 1, 2); alu(6, 5, 5); nop();
        check("gap_fa", 32'(forwarda), 32'd1);
        check("gap_fb", 32'(forwardb), 32'd1);

        // Two writers of r5: the younger (MEM) wins; rt=r0 never forwards.
        alu(5, 1, 2); alu(5, 3, 4); alu(7, 5, 0); nop();
        check("memwb_fa", 32'(forwarda), 32'd2);
        check("memwb_fb", 32'(forwardb), 32'd0);

        // Load-use: one stall, then WB forward.
        lw(4);
        alu(7, 4, 0);
        check("lu_pc", 32'(pc_write), 32'd0);
        check("lu_bubble", 32'(bubble_id_ex), 32'd1);
        check("lu_flush", 32'(flush_if_id), 32'd0);
        alu(7, 4, 0);
        check("lu_release_pc", 32'(pc_write), 32'd1);
        check("lu_cnt", 32'(stall_count), 32'd1);
        nop();
        check("lu_fa", 32'(forwarda), 32'd1);

        // Branch beats load-use, no stall counted.
        lw(4);
        step(4, 0, 7, 1, 1, 1, 0, 1, 0, 0);
        check("br_flush", 32'(flush_if_id), 32'd1);
        check("br_bubble", 32'(bubble_id_ex), 32'd1);
        check("br_pc", 32'(pc_write), 32'd1);
        nop();
        check("br_cnt", 32'(stall_count), 32'd1);
        check("br_fa", 32'(forwarda), 32'd0);

        // Freeze over a load-use hazard for three cycles.
        lw(4);
        for (int i = 0; i < 3; i++) begin
            step(4, 0, 7, 1, 1, 1, 0, 0, 1, 0);
            check("frz_pc", 32'(pc_write), 32'd0);
            check("frz_bubble", 32'(bubble_id_ex), 32'd0);
            check("frz_cnt", 32'(stall_count), 32'd1);
        end
        alu(7, 4, 0);
        check("frz_stall_pc", 32'(pc_write), 32'd0);
        check("frz_stall_bubble", 32'(bubble_id_ex), 32'd1);
        alu(7, 4, 0);
        check("frz_after_pc", 32'(pc_write), 32'd1);
        check("frz_after_cnt", 32'(stall_count), 32'd2);
        nop();

        // Writer and reader of r0: no forwarding, no stall.
        alu(0, 1, 2); alu(8, 0, 0); nop();
        check("r0_fa", 32'(forwarda), 32'd0);
        check("r0_fb", 32'(forwardb), 32'd0);
        lw(0); alu(8, 0, 0);
        check("r0_lu_pc", 32'(pc_write), 32'd1);

        // Reset mid-stall clears everything.
        lw(4);
        step(4, 0, 7, 1, 1, 1, 0, 0, 0, 1);
        check("rst_mid_pc", 32'(pc_write), 32'd1);
        nop();
        check("rst_mid_cnt", 32'(stall_count), 32'd0);

        // Randomized traffic over a small register set to force collisions.
        for (int i = 0; i < 3000; i++) begin
            bit rw;
            rw = 1'($urandom_range(0, 3) != 0);
            step(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rw, rw & 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 99) == 0));
        end

        // Saturation: more load-use stalls than the counter can hold.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < CMAX + 6; i++) begin
            lw(4); alu(7, 4, 0); alu(7, 4, 0);
        end
        nop();
        check("sat_cnt", 32'(stall_count), 32'(CMAX));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Sequencing controller for the EX-stage operand forwarding muxes of the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Keeps a shadow pipeline of destination-register info and drives the registered forward selects for the A and B operand muxes.
- Drives load-use stall, branch flush and global-freeze controls, plus a saturating stall counter for performance monitoring.
- Sits beside the ID/EX pipeline register; its outputs feed the operand forwarding muxes, the PC/IF-ID write enables and the ID/EX bubble insertion.

Parameters:
- REG_AW, 5, register-address width
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- id_rs  in  REG_AW  source A address of the instruction in ID
- id_rt  in  REG_AW  source B address of the instruction in ID
- id_rd  in  REG_AW  destination address of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_regwrite  in  1  ID instruction writes a register
- id_memread  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch in EX resolved taken this cycle
- mem_wait  in  1  data memory not ready; freeze the whole pipeline
- forwarda  out  2  EX operand-A select: 00 register file, 01 WB data, 10 MEM ALU result
- forwardb  out  2  EX operand-B select, same encoding
- pc_write  out  1  PC/IF-ID write enable (0 = hold)
- flush_if_id  out  1  clear IF/ID register
- bubble_id_ex  out  1  load NOP into ID/EX
- stall_count  out  CNT_W  cycles lost to load-use stalls, saturating

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: all shadow stages invalid (rd=0, regwrite=0, memread=0), forwarda=forwardb=00, stall_count=0.
- Combinational outputs: pc_write, flush_if_id and bubble_id_ex are combinational from current inputs and shadow state. During reset they read 1/0/0.
- Shadow pipeline: three stages ex_, mem_, wb_, each holding {rd, regwrite, memread}. A stage with rd==0 never matches any source.
- Load-use hazard:
  - Condition: ex_memread & ex_regwrite & ex_rd!=0 & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
  - Response: pc_write=0, bubble_id_ex=1.
  - Exactly one stall cycle per load, because the load has moved to MEM on the next cycle.
- Branch: ex_branch_taken → flush_if_id=1, bubble_id_ex=1, pc_write=1. Branch beats load-use; no stall is counted.
- Freeze: mem_wait=1 → pc_write=0, flush_if_id=0, bubble_id_ex=0.
  - All shadow stages, forward selects and stall_count hold.
  - Freeze beats branch and load-use; those events are re-evaluated when mem_wait drops.
- Advance, on each clk edge when not frozen:
  - wb_ ← mem_, mem_ ← ex_.
  - ex_ ← ID info, or an invalid entry if bubble_id_ex.
- Forward selects are registered. They are computed at ID from the pre-advance shadow stages, so during EX they describe the MEM/WB producers.
  - forwarda next = 10 if ex_regwrite & ex_rd!=0 & ex_rd==id_rs & id_uses_rs.
  - Otherwise 01 if mem_regwrite & mem_rd!=0 & mem_rd==id_rs & id_uses_rs.
  - Otherwise 00.
  - MEM has priority over WB. forwardb is identical using id_rt/id_uses_rt.
  - When bubble_id_ex, the next forward selects are 00.
- stall_count: +1 per cycle with a load-use stall and no branch and no freeze. Saturates at all-ones with no wrap.
- Reset mid-stall or mid-freeze: everything returns to reset values on the next edge. No pending stall survives.

Decomposition:
- Shared package cpu_pkg holds:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - REG_AW
  - the stage-info struct {rd, regwrite, memread}
- One natural sub-module, fwd_select: compares one source address against the ex_/mem_ entries and returns the 2-bit select. Instantiated twice (A, B).

Test Plan:
- After reset, ID add r3←r1,r2 with no prior writers → forwarda=forwardb=00, pc_write=1, stall_count=0.
- add r5←… then sub r6←r5,r5 back-to-back → in sub's EX cycle forwarda=forwardb=10. With one independent instruction between them → 01.
- Two writers to r5 in consecutive instructions, then reader of r5 → forwarda=10 (MEM beats WB).
- lw r4 then add r7←r4,r0 → one cycle pc_write=0, bubble_id_ex=1, stall_count=1. Next cycle add advances with forwarda=01.
- lw r4, dependent add, and ex_branch_taken=1 in the same cycle → flush_if_id=1, bubble_id_ex=1, pc_write=1, stall_count unchanged.
- mem_wait=1 for 3 cycles during a load-use hazard → outputs frozen and stall_count held; the stall occurs once after release. Writer/reader on r0 → selects remain 00.
